// File: rtl/oled_bus_arbiter.sv
// ---------------------------------------------------------------------------
// oled_bus_arbiter
//
// Shares one OLED byte-writer (SPI/I2C serializer) between NREQ requesters
// (0 = init sequencer, 1 = screen clear, 2 = text renderer). The arbiter
// grants whole bursts, so command sequences from different clients are never
// interleaved. Priority is fixed (index 0 highest) and a running burst is
// never preempted.
//
// Optional feature: define ARB_TIMEOUT_EN to add a burst idle timeout. It
// adds the TMO_CYC parameter and a 1-bit tmo pulse output.
//
// Ports:
//   clk_50m     system clock
//   rst         asynchronous, active-high reset
//   req         per-requester bus request (level, held until burst done)
//   vld/dat/dc  per-requester byte offer; dat slice i is [8i+7:8i]
//   last        per-requester end-of-burst marker
//   gnt         registered one-hot grant
//   rdy         per-requester byte accepted this cycle
//   wr_valid    byte available to the serializer (registered)
//   wr_data     byte to the serializer (registered)
//   wr_dc       D/C flag to the serializer (registered)
//   wr_ready    serializer accepts the byte
//   busy        a burst is in progress (state != IDLE)
//   burst_cnt   bytes accepted in the current/last burst (saturating)
//   state_dbg   current FSM state (0 IDLE, 1 BURST, 2 DRAIN, 3 RELEASE)
//   tmo         (ARB_TIMEOUT_EN only) 1-cycle pulse on burst timeout
//
// Handshake: a byte moves across an interface on every clock edge where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that edge. This applies to vld/rdy on the client side and to
// wr_valid/wr_ready on the serializer side.
// ---------------------------------------------------------------------------
module oled_bus_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 1023
`endif
) (
    input  logic                clk_50m,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     vld,
    input  logic [8*NREQ-1:0]   dat,
    input  logic [NREQ-1:0]     dc,
    input  logic [NREQ-1:0]     last,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rdy,
    output logic                wr_valid,
    output logic [7:0]          wr_data,
    output logic                wr_dc,
    input  logic                wr_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    burst_cnt,
    output logic [1:0]          state_dbg
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                tmo
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BURST   = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state;
    logic [NREQ-1:0] pick_oh;
    logic [7:0]      sel_dat;
    logic            sel_dc;
    logic            sel_last;
    logic            out_free;
    logic            accept;

    // Isolate the lowest set request bit: highest priority wins.
    assign pick_oh = req & (~req + NREQ'(1));

    // The output register can take a new byte if it is empty or draining
    // this same cycle, which gives full rate with no skid buffer.
    assign out_free = !wr_valid || wr_ready;
    assign rdy      = (state == S_BURST && out_free) ? (gnt & vld) : '0;
    assign accept   = |rdy;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // gnt is one-hot, so an AND-OR mux selects the granted client's byte.
    always_comb begin
        sel_dat  = '0;
        sel_dc   = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_dat  = sel_dat | dat[8*i +: 8];
                sel_dc   = sel_dc | dc[i];
                sel_last = sel_last | last[i];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             sel_vld;
    logic             tmo_hit;

    assign sel_vld = |(gnt & vld);
    // Fires on the TMO_CYC-th consecutive cycle without an offered byte.
    assign tmo_hit = (state == S_BURST) && !sel_vld &&
                     (tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            tmo <= tmo_hit;
            if (state != S_BURST || accept)
                tmo_cnt <= '0;
            else if (!sel_vld)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            wr_valid  <= 1'b0;
            wr_data   <= '0;
            wr_dc     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            // Output register: a load takes precedence over a drain.
            if (accept) begin
                wr_valid <= 1'b1;
                wr_data  <= sel_dat;
                wr_dc    <= sel_dc;
            end else if (wr_valid && wr_ready) begin
                wr_valid <= 1'b0;
            end

            if (accept && burst_cnt != '1)
                burst_cnt <= burst_cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt       <= pick_oh;
                        burst_cnt <= '0;
                        state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (accept && sel_last)
                        state <= S_DRAIN;
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_hit)
                        state <= S_DRAIN;
`endif
                end
                S_DRAIN: begin
                    // Hold the grant until the last byte has left the
                    // output register.
                    if (out_free) begin
                        gnt   <= '0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oled_bus_arbiter
//
// Directed bench for oled_bus_arbiter: single burst, priority, no
// preemption, backpressure, reset mid-burst and (with ARB_TIMEOUT_EN) the
// burst idle timeout. Bytes leaving the serializer port are checked against
// an expected queue filled as bytes are offered.
// ---------------------------------------------------------------------------
module tb_oled_bus_arbiter;

    localparam int NREQ  = 3;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk_50m = 1'b0;
    logic rst     = 1'b0;
    always #10 clk_50m = ~clk_50m;

    logic [NREQ-1:0]   req      = '0;
    logic [NREQ-1:0]   vld      = '0;
    logic [8*NREQ-1:0] dat      = '0;
    logic [NREQ-1:0]   dc       = '0;
    logic [NREQ-1:0]   last     = '0;
    logic              wr_ready = 1'b1;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rdy;
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_dc;
    logic              busy;
    logic [CNT_W-1:0]  burst_cnt;
    logic [1:0]        state_dbg;
`ifdef ARB_TIMEOUT_EN
    logic              tmo;
`endif

    oled_bus_arbiter #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
`ifdef ARB_TIMEOUT_EN
        ,
        .TMO_CYC (8)
`endif
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .req       (req),
        .vld       (vld),
        .dat       (dat),
        .dc        (dc),
        .last      (last),
        .gnt       (gnt),
        .rdy       (rdy),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_dc     (wr_dc),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .burst_cnt (burst_cnt),
        .state_dbg (state_dbg)
`ifdef ARB_TIMEOUT_EN
        ,
        .tmo       (tmo)
`endif
    );

    // ---------------- scoreboard ----------------
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];   // {dc, data}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Serializer side: every handshake must deliver the next expected byte.
    always @(negedge clk_50m) begin
        if (!rst && wr_valid && wr_ready) begin
            n_chk++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_extra observed=0x%0h expected=none", {wr_dc, wr_data});
            end
            if (exp_q.size() > 0)
                chk("sb_byte", 32'({wr_dc, wr_data}), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_50m);
        #2;
    endtask

    // Offer one byte from requester k and wait (bounded) for acceptance.
    task automatic send_byte(input int k, input logic [7:0] d, input logic c, input logic l);
        int waited;
        waited = 0;
        vld[k]        = 1'b1;
        dat[8*k +: 8] = d;
        dc[k]         = c;
        last[k]       = l;
        #1;
        while (rdy[k] !== 1'b1 && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        chk("rdy_wait", 32'(rdy[k]), 32'd1);
        exp_q.push_back({c, d});
        tick();
        vld[k]  = 1'b0;
        last[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] init_seq [4];
        init_seq[0] = 8'hAE; init_seq[1] = 8'hD5;
        init_seq[2] = 8'h80; init_seq[3] = 8'hA8;

        // Reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_wr_valid",  32'(wr_valid),  32'd0);
        chk("rst_wr_data",   32'(wr_data),   32'd0);
        chk("rst_wr_dc",     32'(wr_dc),     32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("rst_state",     32'(state_dbg), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single burst from requester 0, 4 command bytes
        req = 3'b001;
        tick();
        chk("single_gnt",   32'(gnt),       32'b001);
        chk("single_busy",  32'(busy),      32'd1);
        chk("single_cnt0",  32'(burst_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_byte(0, init_seq[i], 1'b0, i == 3);
            chk("single_data",  32'(wr_data),  32'(init_seq[i]));
            chk("single_valid", 32'(wr_valid), 32'd1);
        end
        req = 3'b000;
        chk("single_cnt4",  32'(burst_cnt), 32'd4);
        chk("single_drain", 32'(state_dbg), 32'd2);
        tick();
        chk("single_rel_gnt",   32'(gnt),       32'd0);
        chk("single_rel_state", 32'(state_dbg), 32'd3);
        chk("single_rel_busy",  32'(busy),      32'd1);
        chk("single_rel_valid", 32'(wr_valid),  32'd0);
        tick();
        chk("single_idle_busy", 32'(busy),      32'd0);
        chk("single_cnt_hold",  32'(burst_cnt), 32'd4);

        // Priority: 1 and 2 request together, 1 wins
        req = 3'b110;
        tick();
        chk("prio_gnt1", 32'(gnt), 32'b010);
        // Ungranted requester offering a byte is ignored
        vld[2] = 1'b1; dat[23:16] = 8'hEE;
        #1;
        chk("prio_ungranted_rdy", 32'(rdy), 32'd0);
        vld[2] = 1'b0;
        send_byte(1, 8'h00, 1'b1, 1'b0);
        send_byte(1, 8'hFF, 1'b1, 1'b1);
        req[1] = 1'b0;
        chk("prio_drain_gnt", 32'(gnt), 32'b010);
        chk("prio_drain_rdy", 32'(rdy), 32'd0);
        tick();
        chk("prio_rel_gnt", 32'(gnt), 32'd0);
        tick();
        chk("prio_idle_gnt", 32'(gnt), 32'd0);
        tick();
        chk("prio_gnt2",    32'(gnt),       32'b100);
        chk("prio_cnt_clr", 32'(burst_cnt), 32'd0);

        // No preemption: req[0] rises after byte 3 of 10
        for (int i = 0; i < 10; i++) begin
            if (i == 3) req[0] = 1'b1;
            send_byte(2, 8'(8'h30 + i), 1'b1, i == 9);
            chk("nopre_gnt", 32'(gnt), 32'b100);
        end
        req[2] = 1'b0;
        chk("nopre_cnt10", 32'(burst_cnt), 32'd10);
        tick();
        chk("nopre_rel_gnt", 32'(gnt), 32'd0);
        tick();
        tick();
        chk("nopre_gnt0", 32'(gnt), 32'b001);

        // Backpressure: serializer stalls for 5 cycles
        send_byte(0, 8'h11, 1'b1, 1'b0);
        wr_ready      = 1'b0;
        vld[0]        = 1'b1;
        dat[7:0]      = 8'h22;
        dc[0]         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 32'(rdy[0]), 32'd0);
            tick();
            chk("bp_valid", 32'(wr_valid),  32'd1);
            chk("bp_data",  32'(wr_data),   32'h11);
            chk("bp_dc",    32'(wr_dc),     32'd1);
            chk("bp_cnt",   32'(burst_cnt), 32'd1);
        end
        wr_ready = 1'b1;
        #1;
        chk("bp_rdy_resume", 32'(rdy[0]), 32'd1);
        exp_q.push_back({1'b1, 8'h22});
        tick();
        vld[0] = 1'b0;
        chk("bp_data2", 32'(wr_data),   32'h22);
        chk("bp_cnt2",  32'(burst_cnt), 32'd2);
        send_byte(0, 8'h33, 1'b1, 1'b1);
        req[0] = 1'b0;
        tick();
        tick();
        chk("bp_cnt3", 32'(burst_cnt), 32'd3);
        chk("bp_idle", 32'(busy),      32'd0);

        // Reset mid-burst after 2 of 6 bytes
        req = 3'b010;
        tick();
        chk("rstmid_gnt", 32'(gnt), 32'b010);
        send_byte(1, 8'hAA, 1'b0, 1'b0);
        send_byte(1, 8'hBB, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_gnt0",   32'(gnt),          32'd0);
        chk("rstmid_valid",  32'(wr_valid),     32'd0);
        chk("rstmid_busy",   32'(busy),         32'd0);
        chk("rstmid_cnt",    32'(burst_cnt),    32'd0);
        chk("rstmid_lost",   32'(exp_q.size()), 32'd1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_regnt", 32'(gnt), 32'b010);
        send_byte(1, 8'hCC, 1'b0, 1'b1);
        req[1] = 1'b0;
        tick();
        tick();
        chk("rstmid_cnt1", 32'(burst_cnt), 32'd1);

`ifdef ARB_TIMEOUT_EN
        // Timeout: requester 2 stalls after one byte, never sends last
        req = 3'b100;
        tick();
        chk("tmo_gnt", 32'(gnt), 32'b100);
        send_byte(2, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("tmo_quiet", 32'(tmo), 32'd0);
        end
        tick();
        chk("tmo_pulse", 32'(tmo),       32'd1);
        chk("tmo_drain", 32'(state_dbg), 32'd2);
        req[2] = 1'b0;
        tick();
        chk("tmo_pulse_end", 32'(tmo), 32'd0);
        tick();
        chk("tmo_idle", 32'(busy), 32'd0);
`endif

        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
